// File: rtl/floor_request_scheduler_if.sv
// Call/cabin/target signal bundle between the floor request scheduler and its lift environment.
interface floor_request_scheduler_if;
    logic       hall_call_vld;
    logic [2:0] hall_call_f;
    logic       cab_call_vld;
    logic [2:0] cab_call_f;
    logic [2:0] elev_f_i;
    logic       busy_i;
    logic [2:0] tgt_f_o;
    logic       tgt_vld_o;
    logic [1:0] dir_o;
    logic [7:0] pending_o;
    logic [3:0] req_cnt_o;

    modport master (
        output hall_call_vld, hall_call_f, cab_call_vld, cab_call_f, elev_f_i, busy_i,
        input  tgt_f_o, tgt_vld_o, dir_o, pending_o, req_cnt_o
    );

    modport slave (
        input  hall_call_vld, hall_call_f, cab_call_vld, cab_call_f, elev_f_i, busy_i,
        output tgt_f_o, tgt_vld_o, dir_o, pending_o, req_cnt_o
    );
endinterface

// File: rtl/floor_request_scheduler.sv
// Eight-floor elevator request scheduler (collective up/down sweep).
// Define SCHED_HOLD_EN to make the cabin dwell HOLD_CYC cycles at each served floor.
module floor_request_scheduler #(
    parameter int HOLD_CYC = 4
) (
    input  logic clk,
    input  logic rst_n,
    floor_request_scheduler_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_UP   = 2'b01,
        S_DOWN = 2'b10,
        S_HOLD = 2'b11
    } state_t;

    if (HOLD_CYC < 1) begin : g_hold_cyc_check
        $error("HOLD_CYC must be at least 1");
    end

    function automatic logic [7:0] onehot(input logic [2:0] f);
        return 8'd1 << f;
    endfunction

    function automatic logic [7:0] gt_mask(input logic [2:0] f);
        return 8'hFF << (4'(f) + 4'd1);
    endfunction

    function automatic logic [7:0] ge_mask(input logic [2:0] f);
        return 8'hFF << f;
    endfunction

    function automatic logic [2:0] lowest_set(input logic [7:0] m);
        logic [2:0] idx;
        idx = '0;
        for (int i = 7; i >= 0; i--) begin
            if (m[i]) idx = 3'(i);
        end
        return idx;
    endfunction

    function automatic logic [2:0] highest_set(input logic [7:0] m);
        logic [2:0] idx;
        idx = '0;
        for (int i = 0; i < 8; i++) begin
            if (m[i]) idx = 3'(i);
        end
        return idx;
    endfunction

    function automatic logic [3:0] popcount(input logic [7:0] m);
        logic [3:0] c;
        c = '0;
        for (int i = 0; i < 8; i++) begin
            c = c + 4'(m[i]);
        end
        return c;
    endfunction

    // Sweep continuation: keep the current direction while work remains ahead.
    function automatic state_t resolve_dir(input logic going_up, input logic any_above,
                                           input logic any_below);
        if (going_up) return any_above ? S_UP : (any_below ? S_DOWN : S_IDLE);
        return any_below ? S_DOWN : (any_above ? S_UP : S_IDLE);
    endfunction

    state_t     state_q, state_n;
    logic [7:0] pending_q, pending_n;
    logic [2:0] last_tgt_q;

`ifdef SCHED_HOLD_EN
    localparam int CNT_W = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
    logic [CNT_W-1:0] hold_cnt_q, hold_cnt_n;
    logic             last_up_q, last_up_n;
`endif

    logic [2:0] elev;
    logic [7:0] above_s, below_s, up_cand, dn_cand;
    logic [7:0] set_mask, clr_mask, discard_mask;
    logic [2:0] up_tgt, dn_tgt, near_up, near_dn, tgt_cur;
    logic       tgt_vld, arrival, rem_above, rem_below;

    assign elev    = bus.elev_f_i;
    assign above_s = pending_q & gt_mask(elev);
    assign below_s = pending_q & ~ge_mask(elev);
    // Targets include the current floor so the cabin can actually arrive at them.
    assign up_cand = pending_q & ge_mask(elev);
    assign dn_cand = pending_q & ~gt_mask(elev);
    assign up_tgt  = lowest_set(up_cand);
    assign dn_tgt  = highest_set(dn_cand);
    assign near_up = lowest_set(above_s);
    assign near_dn = highest_set(below_s);

    assign tgt_vld = ((state_q == S_UP) && (|up_cand)) || ((state_q == S_DOWN) && (|dn_cand));
    assign tgt_cur = (state_q == S_UP) ? up_tgt : dn_tgt;
    assign arrival = tgt_vld && !bus.busy_i && (elev == tgt_cur);

    assign set_mask = (bus.hall_call_vld ? onehot(bus.hall_call_f) : 8'h00)
                    | (bus.cab_call_vld  ? onehot(bus.cab_call_f)  : 8'h00);
    assign discard_mask = ((state_q == S_IDLE) && !bus.busy_i) ? onehot(elev) : 8'h00;
    assign clr_mask     = arrival ? onehot(tgt_cur) : 8'h00;
    assign pending_n    = (pending_q | set_mask) & ~clr_mask & ~discard_mask;

    assign rem_above = |(pending_n & gt_mask(elev));
    assign rem_below = |(pending_n & ~ge_mask(elev));

    always_comb begin
        state_n = state_q;
`ifdef SCHED_HOLD_EN
        hold_cnt_n = hold_cnt_q;
        last_up_n  = last_up_q;
`endif
        case (state_q)
            S_IDLE: begin
                if ((|above_s) && (|below_s)) begin
                    state_n = ((elev - near_dn) < (near_up - elev)) ? S_DOWN : S_UP;
                end else if (|above_s) begin
                    state_n = S_UP;
                end else if (|below_s) begin
                    state_n = S_DOWN;
                end
            end
            S_UP, S_DOWN: begin
                if (!tgt_vld) begin
                    state_n = S_IDLE;
                end else if (arrival) begin
`ifdef SCHED_HOLD_EN
                    state_n    = S_HOLD;
                    hold_cnt_n = '0;
                    last_up_n  = (state_q == S_UP);
`else
                    state_n = resolve_dir(state_q == S_UP, rem_above, rem_below);
`endif
                end
            end
            S_HOLD: begin
`ifdef SCHED_HOLD_EN
                if (hold_cnt_q == CNT_W'(HOLD_CYC - 1)) begin
                    state_n = resolve_dir(last_up_q, rem_above, rem_below);
                end else begin
                    hold_cnt_n = hold_cnt_q + 1'b1;
                end
`else
                state_n = S_IDLE;
`endif
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            state_q    <= S_IDLE;
            pending_q  <= '0;
            last_tgt_q <= '0;
`ifdef SCHED_HOLD_EN
            hold_cnt_q <= '0;
            last_up_q  <= 1'b0;
`endif
        end else begin
            state_q   <= state_n;
            pending_q <= pending_n;
            if (tgt_vld) last_tgt_q <= tgt_cur;
`ifdef SCHED_HOLD_EN
            hold_cnt_q <= hold_cnt_n;
            last_up_q  <= last_up_n;
`endif
        end
    end

    assign bus.tgt_vld_o = tgt_vld;
    assign bus.tgt_f_o   = tgt_vld ? tgt_cur : last_tgt_q;
    assign bus.dir_o     = state_q;
    assign bus.pending_o = pending_q;
    assign bus.req_cnt_o = popcount(pending_q);

endmodule

// File: tb/tb_floor_request_scheduler.sv
// Directed bench for floor_request_scheduler; covers both builds of SCHED_HOLD_EN.
module tb_floor_request_scheduler;

    logic clk = 1'b0;
    logic rst_n;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    floor_request_scheduler_if sif();

    floor_request_scheduler #(.HOLD_CYC(4)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (sif)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic hold_wait();
`ifdef SCHED_HOLD_EN
        repeat (4) tick();
`endif
    endtask

    task automatic apply_reset();
        sif.hall_call_vld = 1'b0;
        sif.hall_call_f   = 3'd0;
        sif.cab_call_vld  = 1'b0;
        sif.cab_call_f    = 3'd0;
        sif.elev_f_i      = 3'd0;
        sif.busy_i        = 1'b0;
        rst_n = 1'b1;
        tick();
        tick();
        rst_n = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        n_cmp++;
        if ({sif.tgt_vld_o, sif.dir_o, sif.tgt_f_o} !== 6'd0) begin
            $display("FAIL reset_tgt actual=%b required=000000", {sif.tgt_vld_o, sif.dir_o, sif.tgt_f_o});
            n_bad++;
        end
        n_cmp++;
        if ({sif.pending_o, sif.req_cnt_o} !== 12'd0) begin
            $display("FAIL reset_pending actual=%h/%0d required=00/0", sif.pending_o, sif.req_cnt_o);
            n_bad++;
        end
        rst_n = 1'b1;
        sif.cab_call_vld = 1'b1;
        sif.cab_call_f   = 3'd5;
        tick();
        rst_n = 1'b0;
        sif.cab_call_vld = 1'b0;
        n_cmp++;
        if (sif.pending_o !== 8'h00) begin
            $display("FAIL reset_overrides_strobe actual=%h required=00", sif.pending_o);
            n_bad++;
        end
    endtask

    task automatic test_basic_up();
        apply_reset();
        sif.cab_call_vld = 1'b1;
        sif.cab_call_f   = 3'd5;
        tick();
        sif.cab_call_vld = 1'b0;
        n_cmp++;
        if (sif.pending_o !== 8'h20) begin
            $display("FAIL basic_pending actual=%h required=20", sif.pending_o);
            n_bad++;
        end
        n_cmp++;
        if ({sif.tgt_vld_o, sif.dir_o} !== 3'b000) begin
            $display("FAIL basic_still_idle actual=%b required=000", {sif.tgt_vld_o, sif.dir_o});
            n_bad++;
        end
        tick();
        n_cmp++;
        if ({sif.tgt_vld_o, sif.dir_o, sif.tgt_f_o} !== {1'b1, 2'b01, 3'd5}) begin
            $display("FAIL basic_target actual=%b required=101101", {sif.tgt_vld_o, sif.dir_o, sif.tgt_f_o});
            n_bad++;
        end
        n_cmp++;
        if (sif.req_cnt_o !== 4'd1) begin
            $display("FAIL basic_count actual=%0d required=1", sif.req_cnt_o);
            n_bad++;
        end
    endtask

    task automatic test_retarget();
        apply_reset();
        sif.elev_f_i     = 3'd2;
        sif.cab_call_vld = 1'b1;
        sif.cab_call_f   = 3'd6;
        tick();
        sif.cab_call_vld = 1'b0;
        tick();
        n_cmp++;
        if ({sif.tgt_vld_o, sif.dir_o, sif.tgt_f_o} !== {1'b1, 2'b01, 3'd6}) begin
            $display("FAIL retarget_initial actual=%b required=101110", {sif.tgt_vld_o, sif.dir_o, sif.tgt_f_o});
            n_bad++;
        end
        sif.busy_i        = 1'b1;
        sif.hall_call_vld = 1'b1;
        sif.hall_call_f   = 3'd4;
        tick();
        sif.hall_call_vld = 1'b0;
        n_cmp++;
        if ({sif.tgt_vld_o, sif.tgt_f_o} !== {1'b1, 3'd4}) begin
            $display("FAIL retarget_enroute actual=%b required=1100", {sif.tgt_vld_o, sif.tgt_f_o});
            n_bad++;
        end
        sif.elev_f_i = 3'd4;
        sif.busy_i   = 1'b0;
        tick();
        n_cmp++;
        if (sif.pending_o !== 8'h40) begin
            $display("FAIL retarget_clear actual=%h required=40", sif.pending_o);
            n_bad++;
        end
`ifdef SCHED_HOLD_EN
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if ({sif.tgt_vld_o, sif.dir_o, sif.tgt_f_o} !== {1'b0, 2'b11, 3'd4}) begin
                $display("FAIL hold_cycle%0d actual=%b required=011100", i, {sif.tgt_vld_o, sif.dir_o, sif.tgt_f_o});
                n_bad++;
            end
            tick();
        end
`endif
        n_cmp++;
        if ({sif.tgt_vld_o, sif.dir_o, sif.tgt_f_o} !== {1'b1, 2'b01, 3'd6}) begin
            $display("FAIL retarget_next actual=%b required=101110", {sif.tgt_vld_o, sif.dir_o, sif.tgt_f_o});
            n_bad++;
        end
        sif.elev_f_i = 3'd6;
        tick();
        n_cmp++;
        if (sif.pending_o !== 8'h00) begin
            $display("FAIL retarget_last_clear actual=%h required=00", sif.pending_o);
            n_bad++;
        end
        hold_wait();
        n_cmp++;
        if ({sif.tgt_vld_o, sif.dir_o, sif.tgt_f_o} !== {1'b0, 2'b00, 3'd6}) begin
            $display("FAIL retarget_idle_hold_tgt actual=%b required=000110", {sif.tgt_vld_o, sif.dir_o, sif.tgt_f_o});
            n_bad++;
        end
    endtask

    task automatic test_tie();
        apply_reset();
        sif.elev_f_i      = 3'd3;
        sif.hall_call_vld = 1'b1;
        sif.hall_call_f   = 3'd1;
        sif.cab_call_vld  = 1'b1;
        sif.cab_call_f    = 3'd5;
        tick();
        sif.hall_call_vld = 1'b0;
        sif.cab_call_vld  = 1'b0;
        n_cmp++;
        if ({sif.pending_o, sif.req_cnt_o} !== {8'h22, 4'd2}) begin
            $display("FAIL tie_pending actual=%h/%0d required=22/2", sif.pending_o, sif.req_cnt_o);
            n_bad++;
        end
        tick();
        n_cmp++;
        if ({sif.tgt_vld_o, sif.dir_o, sif.tgt_f_o} !== {1'b1, 2'b01, 3'd5}) begin
            $display("FAIL tie_goes_up actual=%b required=101101", {sif.tgt_vld_o, sif.dir_o, sif.tgt_f_o});
            n_bad++;
        end
        sif.elev_f_i = 3'd5;
        tick();
        hold_wait();
        n_cmp++;
        if ({sif.tgt_vld_o, sif.dir_o, sif.tgt_f_o} !== {1'b1, 2'b10, 3'd1}) begin
            $display("FAIL tie_reverse actual=%b required=110001", {sif.tgt_vld_o, sif.dir_o, sif.tgt_f_o});
            n_bad++;
        end
        n_cmp++;
        if (sif.pending_o !== 8'h02) begin
            $display("FAIL tie_after_five actual=%h required=02", sif.pending_o);
            n_bad++;
        end
        sif.elev_f_i = 3'd1;
        tick();
        hold_wait();
        n_cmp++;
        if ({sif.tgt_vld_o, sif.dir_o, sif.req_cnt_o} !== {1'b0, 2'b00, 4'd0}) begin
            $display("FAIL tie_idle actual=%b required=0000000", {sif.tgt_vld_o, sif.dir_o, sif.req_cnt_o});
            n_bad++;
        end
    endtask

    task automatic test_same_floor();
        apply_reset();
        sif.hall_call_vld = 1'b1;
        sif.hall_call_f   = 3'd7;
        sif.cab_call_vld  = 1'b1;
        sif.cab_call_f    = 3'd7;
        tick();
        sif.hall_call_vld = 1'b0;
        n_cmp++;
        if ({sif.pending_o, sif.req_cnt_o} !== {8'h80, 4'd1}) begin
            $display("FAIL dup_floor actual=%h/%0d required=80/1", sif.pending_o, sif.req_cnt_o);
            n_bad++;
        end
        sif.cab_call_f = 3'd3;
        tick();
        sif.cab_call_vld = 1'b0;
        n_cmp++;
        if ({sif.tgt_vld_o, sif.tgt_f_o, sif.req_cnt_o} !== {1'b1, 3'd3, 4'd2}) begin
            $display("FAIL absorb_setup actual=%b required=10110010", {sif.tgt_vld_o, sif.tgt_f_o, sif.req_cnt_o});
            n_bad++;
        end
        sif.elev_f_i      = 3'd3;
        sif.hall_call_vld = 1'b1;
        sif.hall_call_f   = 3'd3;
        tick();
        sif.hall_call_vld = 1'b0;
        n_cmp++;
        if ({sif.pending_o, sif.req_cnt_o} !== {8'h80, 4'd1}) begin
            $display("FAIL absorb_clear_wins actual=%h/%0d required=80/1", sif.pending_o, sif.req_cnt_o);
            n_bad++;
        end
        apply_reset();
        sif.elev_f_i      = 3'd3;
        sif.hall_call_vld = 1'b1;
        sif.hall_call_f   = 3'd3;
        tick();
        sif.hall_call_vld = 1'b0;
        n_cmp++;
        if ({sif.pending_o, sif.req_cnt_o} !== 12'd0) begin
            $display("FAIL discard_current actual=%h/%0d required=00/0", sif.pending_o, sif.req_cnt_o);
            n_bad++;
        end
    endtask

    task automatic test_reset_mid_travel();
        apply_reset();
        sif.cab_call_vld  = 1'b1;
        sif.cab_call_f    = 3'd2;
        sif.hall_call_vld = 1'b1;
        sif.hall_call_f   = 3'd5;
        tick();
        sif.hall_call_vld = 1'b0;
        sif.cab_call_f    = 3'd6;
        tick();
        sif.cab_call_vld = 1'b0;
        n_cmp++;
        if ({sif.tgt_vld_o, sif.dir_o, sif.req_cnt_o} !== {1'b1, 2'b01, 4'd3}) begin
            $display("FAIL mid_setup actual=%b required=1010011", {sif.tgt_vld_o, sif.dir_o, sif.req_cnt_o});
            n_bad++;
        end
        sif.busy_i        = 1'b1;
        rst_n             = 1'b1;
        sif.hall_call_vld = 1'b1;
        sif.hall_call_f   = 3'd4;
        tick();
        rst_n             = 1'b0;
        sif.hall_call_vld = 1'b0;
        n_cmp++;
        if ({sif.tgt_vld_o, sif.dir_o, sif.tgt_f_o} !== 6'd0) begin
            $display("FAIL mid_reset_tgt actual=%b required=000000", {sif.tgt_vld_o, sif.dir_o, sif.tgt_f_o});
            n_bad++;
        end
        n_cmp++;
        if ({sif.pending_o, sif.req_cnt_o} !== 12'd0) begin
            $display("FAIL mid_reset_pending actual=%h/%0d required=00/0", sif.pending_o, sif.req_cnt_o);
            n_bad++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b1;
        test_reset();
        test_basic_up();
        test_retarget();
        test_tie();
        test_same_floor();
        test_reset_mid_travel();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/floor_request_scheduler.md
FLOOR_REQUEST_SCHEDULER -- requirements
Module: floor_request_scheduler

Interface
REQ-001 Parameter: HOLD_CYC, 4, cycles the cabin dwells at a served floor (used only with SCHED_HOLD_EN).
REQ-002 clk  input  1  sole clock, all state updates on rising edge.
REQ-003 rst_n  input  1  synchronous, active-high reset; the name is kept per codebase naming, polarity is high.
REQ-004 hall_call_vld  input  1  floor call-button press strobe, one cycle.
REQ-005 hall_call_f  input  3  floor of hall call, 0..7.
REQ-006 cab_call_vld  input  1  in-cabin floor button strobe, one cycle.
REQ-007 cab_call_f  input  3  floor requested from cabin, 0..7.
REQ-008 elev_f_i  input  3  current cabin floor, from lift elev_f_o.
REQ-009 busy_i  input  1  lift moving/occupied, from lift busy_o.
REQ-010 tgt_f_o  output  3  target floor issued to lift.
REQ-011 tgt_vld_o  output  1  tgt_f_o is valid.
REQ-012 dir_o  output  2  00 idle, 01 up, 10 down, 11 hold.
REQ-013 pending_o  output  8  one bit per floor with an outstanding request.
REQ-014 req_cnt_o  output  4  popcount of pending_o, 0..8.

Function
REQ-015 A vld strobe in cycle N SHALL set pending[f] visible at N+1; hall and cab strobes in the same cycle SHALL both be recorded, same floor counts once.
REQ-016 A request for elev_f_i while state IDLE and busy_i=0 SHALL be discarded.
REQ-017 States IDLE, UP, DOWN, HOLD; state and pending are registered, tgt_f_o/tgt_vld_o/dir_o decoded combinationally from them.
REQ-018 IDLE: no pending -> stay; pending only above -> UP; only below -> DOWN; both -> nearest, tie -> UP.
REQ-019 UP: tgt_f_o = lowest pending floor > elev_f_i; DOWN: tgt_f_o = highest pending floor < elev_f_i; recomputed every cycle, so a new en-route request retargets immediately.
REQ-020 tgt_vld_o SHALL be 1 only in UP/DOWN with a valid target; in IDLE/HOLD tgt_vld_o=0 and tgt_f_o holds last value.
REQ-021 Arrival = UP/DOWN, busy_i=0 and elev_f_i==tgt_f_o; SHALL clear pending[tgt_f_o] next cycle.
REQ-022 After arrival: pending remaining in current direction -> stay; else opposite direction pending -> reverse; else IDLE.
REQ-023 New call to floor being cleared in the arrival cycle SHALL be absorbed (clear wins).
REQ-024 No direction-matching pending while moving (cannot occur except via REQ-023) SHALL re-evaluate as IDLE next cycle.
REQ-025 Latency request->tgt_vld_o from IDLE SHALL be 2 cycles.

Reset
REQ-026 rst_n=1 at a clock edge SHALL force state IDLE, pending 0, tgt_f_o 0, tgt_vld_o 0, dir_o 00, req_cnt_o 0, hold counter 0, overriding any strobe that cycle, including mid-travel.

Configuration
REQ-027 Macro SCHED_HOLD_EN: when defined, arrival SHALL enter HOLD for exactly HOLD_CYC cycles (tgt_vld_o=0, requests still recorded) then apply REQ-022; when undefined HOLD is unreachable, no counter is built, REQ-022 applies directly.

Verification
REQ-028 Reset, elev_f_i=0, cab_call 5 at N -> pending_o=0x20 at N+1, tgt_f_o=5, tgt_vld_o=1, dir_o=01 at N+2.
REQ-029 UP to 6, elev_f_i=2 busy_i=1, hall_call 4 -> tgt_f_o becomes 4; arrive 4 -> pending bit4 clear, tgt_f_o=6.
REQ-030 elev_f_i=3 IDLE, pending 1 and 5 same cycle -> UP (tie), serves 5 then DOWN to 1, then IDLE, req_cnt_o=0.
REQ-031 Hall and cab both floor 7 same cycle -> req_cnt_o=1; call to 3 in arrival cycle at 3 -> not re-queued.
REQ-032 With SCHED_HOLD_EN, HOLD_CYC=4: arrival -> dir_o=11, tgt_vld_o=0 for 4 cycles, then next target; without macro next target the cycle after arrival.
REQ-033 rst_n pulsed during UP with 3 pending -> all outputs zero next cycle.
